// File: rtl/mips_alu_pkg.sv
// Shared constants and field bundles for the ALU issue/retire stage.
package mips_alu_pkg;

  // ALU control line encodings (001-011 are never produced)
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SLL   = 3'b100;
  localparam logic [2:0] ALU_SRL   = 3'b101;
  localparam logic [2:0] ALU_PASSA = 3'b111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;

  // Decoded fields held in the ID/EX register
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [4:0]  dest;
    logic        wr_en;
    logic        illegal;
    logic [31:0] store_data;
  } ex_fields_t;

  // Fields held in the EX/MEM register
  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        wr_en;
    logic        illegal;
  } res_fields_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, ALU-side and memory-side signals of the issue stage.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [15:0] in_imm;
  logic        flush;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [31:0] out_store_data;
  logic [4:0]  out_dest;
  logic        out_wr_en;
  logic        out_illegal;

  // Surrounding pipeline: decode, external ALU and memory stage
  modport master (
    output in_valid, in_opcode, in_funct, in_shamt, in_rt, in_rd,
           in_rs_data, in_rt_data, in_imm, flush, alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_shamt, alu_ctrl, out_valid, out_result,
           out_zero, out_store_data, out_dest, out_wr_en, out_illegal
  );

  // The issue stage itself
  modport slave (
    input  in_valid, in_opcode, in_funct, in_shamt, in_rt, in_rd,
           in_rs_data, in_rt_data, in_imm, flush, alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_shamt, alu_ctrl, out_valid, out_result,
           out_zero, out_store_data, out_dest, out_wr_en, out_illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct translation into ALU operands and control.
module alu_ctrl_decode
  import mips_alu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  output ex_fields_t  dec
);

  // Unsupported encodings fall to an ADD of zeros that writes nothing
  always_comb begin
    dec            = '0;
    dec.ctrl       = ALU_ADD;
    dec.store_data = rt_data;
    case (opcode)
      OP_RTYPE: begin
        dec.dest  = rd;
        dec.wr_en = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: begin dec.a = rs_data; dec.b = rt_data; end
          FN_SLL:  begin dec.a = rt_data; dec.b = {27'b0, shamt};        dec.ctrl = ALU_SLL; end
          FN_SRL:  begin dec.a = rt_data; dec.b = {27'b0, shamt};        dec.ctrl = ALU_SRL; end
          FN_SLLV: begin dec.a = rt_data; dec.b = {27'b0, rs_data[4:0]}; dec.ctrl = ALU_SLL; end
          FN_SRLV: begin dec.a = rt_data; dec.b = {27'b0, rs_data[4:0]}; dec.ctrl = ALU_SRL; end
          default: begin dec.dest = '0; dec.wr_en = 1'b0; dec.illegal = 1'b1; end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        dec.a = rs_data; dec.b = sext16(imm); dec.dest = rt; dec.wr_en = 1'b1;
      end
      OP_SW: begin
        dec.a = rs_data; dec.b = sext16(imm); dec.dest = rt;
      end
      OP_LUI: begin
        dec.a = {imm, 16'b0}; dec.ctrl = ALU_PASSA; dec.dest = rt; dec.wr_en = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX and EX/MEM registers with valid/ready handshakes around an external ALU.
module alu_issue_stage
  import mips_alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);

  ex_fields_t  dec, ex_q, ex_d;
  res_fields_t res_q, res_d;
  logic        ex_valid_q, ex_valid_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        ex_adv, in_ready, accept;

  alu_ctrl_decode u_dec (
    .opcode  (bus.in_opcode),
    .funct   (bus.in_funct),
    .shamt   (bus.in_shamt),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .rs_data (bus.in_rs_data),
    .rt_data (bus.in_rt_data),
    .imm     (bus.in_imm),
    .dec     (dec)
  );

  // Handshake: EX drains into RES whenever RES is free or being consumed
  always_comb begin
    ex_adv   = ex_valid_q && (!out_valid_q || bus.out_ready);
    in_ready = !reset && !bus.flush && (!ex_valid_q || ex_adv);
    accept   = bus.in_valid && in_ready;
  end

  // EX next state: a new accept wins over drain; flush only squashes EX
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    shamt_d    = shamt_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_d       = dec;
      shamt_d    = bus.in_shamt;
    end else if (ex_adv || bus.flush) begin
      ex_valid_d = 1'b0;
    end
  end

  // RES next state: capture ALU outputs on advance, hold while stalled
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (ex_adv) begin
      out_valid_d      = 1'b1;
      res_d.result     = bus.alu_result;
      res_d.zero       = bus.alu_zero;
      res_d.store_data = ex_q.store_data;
      res_d.dest       = ex_q.dest;
      res_d.wr_en      = ex_q.wr_en;
      res_d.illegal    = ex_q.illegal;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ex_q        <= '0;
      res_q       <= '0;
      shamt_q     <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      out_valid_q <= out_valid_d;
      ex_q        <= ex_d;
      res_q       <= res_d;
      shamt_q     <= shamt_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.alu_a          = ex_valid_q ? ex_q.a    : 32'd0;
  assign bus.alu_b          = ex_valid_q ? ex_q.b    : 32'd0;
  assign bus.alu_ctrl       = ex_valid_q ? ex_q.ctrl : 3'd0;
  assign bus.alu_shamt      = shamt_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = res_q.result;
  assign bus.out_zero       = res_q.zero;
  assign bus.out_store_data = res_q.store_data;
  assign bus.out_dest       = res_q.dest;
  assign bus.out_wr_en      = res_q.wr_en;
  assign bus.out_illegal    = res_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench: instruction-level reference model, external ALU model, random + directed stimulus.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if bus();
  alu_issue_stage dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
  } instr_t;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        wr_en;
    logic        illegal;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  logic rnd_ready   = 1'b0;
  logic ready_force = 1'b1;

  // External combinational ALU
  logic [31:0] alu_r;
  always_comb begin
    alu_r = 32'hDEAD_BEEF;
    case (bus.alu_ctrl)
      3'b000: alu_r = bus.alu_a + bus.alu_b;
      3'b100: alu_r = bus.alu_a << bus.alu_b[4:0];
      3'b101: alu_r = bus.alu_a >> bus.alu_b[4:0];
      3'b111: alu_r = bus.alu_a;
      default: alu_r = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Instruction semantics, independent of how the hardware splits them up
  function automatic exp_t ref_model(input instr_t i);
    exp_t        e;
    logic [31:0] simm;
    logic [31:0] r;
    logic        ill;
    simm = {{16{i.imm[15]}}, i.imm};
    r = 32'd0; ill = 1'b0;
    e.wr_en = 1'b1; e.dest = i.rd; e.store_data = i.rt_data;
    case (i.opcode)
      6'h00: case (i.funct)
        6'h20, 6'h21: r = i.rs_data + i.rt_data;
        6'h00: r = i.rt_data << i.shamt;
        6'h02: r = i.rt_data >> i.shamt;
        6'h04: r = i.rt_data << (i.rs_data % 32);
        6'h06: r = i.rt_data >> (i.rs_data % 32);
        default: ill = 1'b1;
      endcase
      6'h08, 6'h09, 6'h23: begin r = i.rs_data + simm; e.dest = i.rt; end
      6'h2B: begin r = i.rs_data + simm; e.dest = i.rt; e.wr_en = 1'b0; end
      6'h0F: begin r = {i.imm, 16'h0000}; e.dest = i.rt; end
      default: ill = 1'b1;
    endcase
    if (ill) begin r = 32'd0; e.wr_en = 1'b0; end
    e.illegal = ill;
    e.result  = r;
    e.zero    = (r == 32'd0);
    return e;
  endfunction

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rs_d,
                                input logic [31:0] rt_d, input logic [15:0] imm);
    instr_t i;
    i.opcode = op; i.funct = fn; i.shamt = sh; i.rt = rt; i.rd = rd;
    i.rs_data = rs_d; i.rt_data = rt_d; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    logic [5:0] ops[13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h08, 6'h09, 6'h23, 6'h2B, 6'h0F, 6'h00, 6'h3F};
    logic [5:0] fns[13] = '{6'h20, 6'h21, 6'h00, 6'h02, 6'h04, 6'h06,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h2A, 6'h00};
    int k;
    k = $urandom_range(0, 12);
    i.opcode = ops[k];
    i.funct  = (k >= 6 && k != 11) ? 6'($urandom) : fns[k];
    if (i.opcode == 6'h00) i.funct = fns[k];
    i.shamt   = 5'($urandom);
    i.rt      = 5'($urandom);
    i.rd      = 5'($urandom);
    i.rs_data = $urandom;
    i.rt_data = ($urandom_range(0, 3) == 0) ? (32'd0 - i.rs_data) : $urandom;
    i.imm     = 16'($urandom);
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.in_opcode  = i.opcode;
    bus.in_funct   = i.funct;
    bus.in_shamt   = i.shamt;
    bus.in_rt      = i.rt;
    bus.in_rd      = i.rd;
    bus.in_rs_data = i.rs_data;
    bus.in_rt_data = i.rt_data;
    bus.in_imm     = i.imm;
    cur_exp        = ref_model(i);
  endtask

  // Offer one instruction; returns just after the edge that accepted it
  task automatic issue(input instr_t i);
    logic ok;
    ok = 1'b0;
    drive(i);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int c;
    ready_force = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: random in the random phase, otherwise forced level
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: record accepts, compare every presented result against the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = exp_q[0];
          chk("out_result", bus.out_result, e.result);
          chk("out_zero", {31'd0, bus.out_zero}, {31'd0, e.zero});
          chk("out_store_data", bus.out_store_data, e.store_data);
          chk("out_wr_en", {31'd0, bus.out_wr_en}, {31'd0, e.wr_en});
          chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, e.illegal});
          if (e.wr_en) chk("out_dest", {27'd0, bus.out_dest}, {27'd0, e.dest});
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    drive(mk(6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_dest", {27'd0, bus.out_dest}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // add latency: two edges from accept to out_valid
    issue(mk(6'h00, 6'h20, 5'd0, 5'd7, 5'd3, 32'd5, 32'd7, 16'd0));
    @(negedge clk);
    chk("add_alu_a", bus.alu_a, 32'd5);
    chk("add_lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("add_lat_valid", {31'd0, bus.out_valid}, 32'd1);
    drain();

    // sll operands
    issue(mk(6'h00, 6'h00, 5'd4, 5'd1, 5'd2, 32'd0, 32'h1, 16'd0));
    @(negedge clk);
    chk("sll_ctrl", {29'd0, bus.alu_ctrl}, 32'd4);
    chk("sll_b", bus.alu_b, 32'd4);
    chk("sll_shamt", {27'd0, bus.alu_shamt}, 32'd4);
    drain();

    // srlv takes the amount from rs[4:0]
    issue(mk(6'h00, 6'h06, 5'd0, 5'd9, 5'd8, 32'h21, 32'h8000_0000, 16'd0));
    @(negedge clk);
    chk("srlv_ctrl", {29'd0, bus.alu_ctrl}, 32'd5);
    chk("srlv_b", bus.alu_b, 32'd1);
    drain();

    // lui and sw
    issue(mk(6'h0F, 6'h00, 5'd0, 5'd4, 5'd0, 32'd0, 32'd0, 16'h1234));
    @(negedge clk);
    chk("lui_ctrl", {29'd0, bus.alu_ctrl}, 32'd7);
    drain();
    issue(mk(6'h2B, 6'h00, 5'd0, 5'd5, 5'd0, 32'h100, 32'hCAFE_F00D, 16'hFFFC));
    drain();

    // Illegal opcode
    issue(mk(6'h3F, 6'h00, 5'd0, 5'd1, 5'd1, 32'h55, 32'h66, 16'h7));
    drain();

    // Back-to-back with memory stage stalled: EX and RES fill, then in_ready drops
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        issue(mk(6'h00, 6'h21, 5'd0, 5'd1, 5'd10, 32'd1, 32'd2, 16'd0));
        issue(mk(6'h08, 6'h00, 5'd0, 5'd11, 5'd0, 32'd100, 32'd0, 16'hFFFF));
        issue(mk(6'h00, 6'h02, 5'd3, 5'd2, 5'd12, 32'd0, 32'hF0, 16'd0));
        issue(mk(6'h0F, 6'h00, 5'd0, 5'd13, 5'd0, 32'd0, 32'd0, 16'hABCD));
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 ready_force = 1'b1;
      end
    join
    drain();

    // Flush squashes EX (addi) while RES (add) is stalled
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    issue(mk(6'h00, 6'h20, 5'd0, 5'd2, 5'd4, 32'd1, 32'd2, 16'd0));
    issue(mk(6'h08, 6'h00, 5'd0, 5'd6, 5'd0, 32'd10, 32'd0, 16'd5));
    bus.flush = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("flush_res_held", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    ready_force = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-stream discards both stages
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    issue(mk(6'h00, 6'h20, 5'd0, 5'd1, 5'd1, 32'd3, 32'd4, 16'd0));
    issue(mk(6'h09, 6'h00, 5'd0, 5'd2, 5'd0, 32'd3, 32'd0, 16'd9));
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_out_result", bus.out_result, 32'd0);
    chk("midrst_alu_a", bus.alu_a, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_no_pulse", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Random stream with random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(rand_instr());
    end
    rnd_ready = 1'b0;
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage issue and retire block that drives the processor's 3-bit-controlled ALU. It accepts decoded instruction fields over a valid/ready handshake and holds them in an ID/EX register. It translates opcode/funct into ALU operands and control lines, then captures the ALU result and Zero flag into an EX/MEM register with its own valid/ready handshake. Sits between the decode stage and the memory stage; the ALU itself stays combinational and external.

## Interface
- No parameters; data width fixed at 32, register index 5.
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  block accepts this cycle
- in_opcode  in  6  instruction[31:26]
- in_funct  in  6  instruction[5:0]
- in_shamt  in  5  instruction[10:6]
- in_rt, in_rd  in  5 each  register indices
- in_rs_data, in_rt_data  in  32 each  register-file read data
- in_imm  in  16  instruction[15:0]
- flush  in  1  squash EX-stage contents
- alu_a, alu_b  out  32 each  ALU operands
- alu_shamt  out  5  ALU shamt
- alu_ctrl  out  3  ALU control lines
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU Zero
- out_valid  out  1  result register holds an instruction
- out_ready  in  1  memory stage consumes
- out_result  out  32  registered ALU result
- out_zero  out  1  registered Zero
- out_store_data  out  32  registered in_rt_data
- out_dest  out  5  destination register index
- out_wr_en  out  1  register write required
- out_illegal  out  1  unsupported instruction

## Operation
- ALU control codes: ADD=000, SLL=100, SRL=101, PASSA=111. Codes 001–011 are never emitted.
- Decode, opcode 0 (R-type):
  - funct 0x20/0x21 (add/addu): A=rs, B=rt, ADD, dest=rd, wr_en=1.
  - funct 0x00 (sll) and 0x02 (srl): A=rt, B={27'b0,shamt}, SLL and SRL respectively, dest=rd.
  - funct 0x04 (sllv) and 0x06 (srlv): A=rt, B={27'b0,rs[4:0]}, SLL and SRL respectively, dest=rd.
- Decode, I-type:
  - 0x08/0x09 (addi/addiu) and 0x23 (lw): A=rs, B=sign-extended imm, ADD, dest=rt, wr_en=1.
  - 0x2B (sw): same operands, wr_en=0.
  - 0x0F (lui): A={imm,16'b0}, B=0, PASSA, dest=rt, wr_en=1.
- Anything else: A=B=0, ADD, wr_en=0, illegal=1. The instruction still retires normally.
- alu_shamt always carries the registered in_shamt.
- While the EX register is empty, alu_a, alu_b and alu_ctrl are driven 0.
- Additions wrap modulo 2^32; no overflow trap.
- Two registered stages, EX (ID/EX) and RES (EX/MEM), each with a valid bit.
  - ex_adv = ex_valid && (!out_valid || out_ready).
  - in_ready = !flush && (!ex_valid || ex_adv).
  - Accept when in_valid && in_ready: load EX and set ex_valid.
  - On ex_adv: load RES from the decoded EX fields and alu_result/alu_zero, and set out_valid.
  - If out_valid && out_ready && !ex_adv: clear out_valid.
- flush: clears ex_valid, and in_ready is 0 that cycle. RES and out_valid are unaffected; an ex_adv in the same cycle still completes, because the EX instruction is already moving to RES.
- RES holds all out_* values stable while out_valid && !out_ready.

## Timing
- Reset clears ex_valid and out_valid. All out_* data, alu_* outputs and in_ready read 0 during reset, and in_ready=1 the cycle after reset deasserts.
- Latency: accepted at edge k, ALU inputs valid in cycle k→k+1, out_valid=1 after edge k+1 (two edges).
- Throughput one instruction per cycle with out_ready held high.
- Full condition: ex_valid && out_valid && !out_ready makes in_ready=0 combinationally.
- Simultaneous accept and ex_adv: EX reloads with the new instruction while the old one moves to RES.
- Reset mid-stream discards both stages; no output pulse.

## Structure
- Package mips_alu_pkg holds:
  - ALU control code constants (ALU_ADD, ALU_SLL, ALU_SRL, ALU_PASSA);
  - opcode and funct constants;
  - a packed struct for decoded EX fields (a, b, ctrl, dest, wr_en, illegal, store_data).
- One combinational sub-module, alu_ctrl_decode: opcode/funct/operands in, decoded struct out. All registers and handshakes stay in alu_issue_stage.

## Test plan
- add, rs=5, rt=7, rd=3 -> two edges later out_valid=1, out_result=12, out_zero=0, out_dest=3, out_wr_en=1.
- sll, rt=0x1, shamt=4 -> alu_ctrl=100, alu_b=4, out_result=0x10. srlv, rt=0x80000000, rs=0x21 -> alu_b=1, out_result=0x40000000.
- lui, imm=0x1234 -> alu_ctrl=111, out_result=0x12340000. sw, rs=0x100, imm=0xFFFC -> out_result=0xFC, out_wr_en=0, out_store_data=rt.
- Back-to-back stream of 4 instructions with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted. No loss or duplication, outputs stable, order preserved on release.
- flush asserted while EX holds addi and RES holds add with out_ready=0 -> addi never appears, add still retires.
- Opcode 0x3F -> out_illegal=1, out_result=0, out_zero=1, out_wr_en=0. Assert reset mid-stream -> out_valid=0 the next cycle.
